cmd_auth: RTL
=============

CMD_AUTH -- requirements
Module: cmd_auth

Interface
REQ-001 Parameter BAUD_DIV, default 2604: clk cycles per UART bit (50 MHz clk, 19200 baud).
REQ-002 Parameter CMD_GO, default 8'h47: power-up command byte ('G').
REQ-003 Parameter CMD_STOP, default 8'h53: stop command byte ('S').
REQ-004 clk  input  1  system clock; single clock domain; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 RX  input  1  asynchronous UART serial line from BLE module; idle high; 8N1, LSB first.
REQ-007 rider_off  input  1  high when load cells report no rider; synchronous to clk.
REQ-008 pwr_up  output  1  high while the Segway is authorized to balance and drive motors.
REQ-009 rx_rdy  output  1  one-cycle pulse when a valid byte has been received.
REQ-010 rx_data  output  8  last valid received byte; holds until the next valid byte.
REQ-011 frm_err  output  1  one-cycle pulse when a frame ends with stop bit = 0.

Function
REQ-012 RX passes through a 2-flop synchronizer; both flops load 1 on reset.
REQ-013 Receiver states: ARM, IDLE, RECV; ARM requires synchronized RX = 1 for BAUD_DIV consecutive cycles before moving to IDLE.
REQ-014 IDLE -> RECV on a synchronized RX falling edge (previous 1, current 0).
REQ-015 In RECV, bits are sampled at BAUD_DIV/2 cycles after the start edge, then every BAUD_DIV cycles: start, 8 data, stop (10 samples).
REQ-016 A start sample of 1 is a false start: return to IDLE; no pulse; rx_data unchanged.
REQ-017 Stop sample of 1: rx_data <= shifted byte and rx_rdy pulses in the same cycle; return to IDLE.
REQ-018 Stop sample of 0: frm_err pulses; byte discarded; rx_data unchanged; go to ARM.
REQ-019 Baud counter is 13 bits wide; bit counter is 4 bits wide; both clear on every state entry.
REQ-020 Auth FSM states: OFF, PWR1, PWR2; pwr_up = 1 in PWR1 and PWR2, 0 in OFF; pwr_up is registered.
REQ-021 OFF -> PWR1 on rx_rdy with rx_data = CMD_GO.
REQ-022 PWR1 -> OFF on rx_rdy with CMD_STOP while rider_off = 1, sampled in the same cycle.
REQ-023 PWR1 -> PWR2 on rx_rdy with CMD_STOP while rider_off = 0; rider_off alone never leaves PWR1.
REQ-024 PWR2 -> OFF when rider_off = 1; PWR2 -> PWR1 on rx_rdy with CMD_GO; if both occur in one cycle, CMD_GO wins (-> PWR1).
REQ-025 Any other byte, or CMD_GO in PWR1, or CMD_STOP in PWR2/OFF: no state change.
REQ-026 Latency: pwr_up changes exactly 1 cycle after the rx_rdy or rider_off edge causing the transition.
REQ-027 Back-to-back frames with one stop bit and no idle gap are received without loss.

Reset
REQ-028 On rst: receiver -> ARM, auth -> OFF, pwr_up = 0, rx_rdy = 0, frm_err = 0, rx_data = 8'h00, counters = 0.
REQ-029 rst during a frame aborts the frame; the partial byte is never reported; ARM blocks a mid-frame 0 bit from being taken as a start.

Structure
REQ-030 Package cmd_auth_pkg holds the receiver state enum, the auth state enum, and the default CMD_GO and CMD_STOP constants.
REQ-031 Sub-module uart_rx (synchronizer, receiver FSM, shift register, counters) feeds the auth FSM in cmd_auth.

Verification
REQ-032 Send 8'h47 with rider_off = 0 -> rx_rdy pulse, rx_data = 8'h47, pwr_up = 1 one cycle later.
REQ-033 From PWR1, send 8'h53 with rider_off = 0 -> pwr_up stays 1 (PWR2); raise rider_off -> pwr_up = 0 one cycle later.
REQ-034 From PWR1, send 8'h53 with rider_off = 1 -> pwr_up = 0 one cycle after rx_rdy.
REQ-035 Frame 8'h47 with stop bit forced 0 -> frm_err pulse, no rx_rdy, pwr_up stays 0; a following clean 8'h47 after 1 idle bit is accepted.
REQ-036 Assert rst mid-frame (after data bit 3) of 8'h47, release -> no rx_rdy for that frame, pwr_up = 0; next full frame is decoded correctly.
REQ-037 Send 8'h47 then 8'h53 back-to-back with no gap -> two rx_rdy pulses exactly 10*BAUD_DIV cycles apart, final state PWR2 (rider_off = 0).

Source files
------------

// File: rtl/cmd_auth_pkg.sv
// Shared types and defaults for the BLE command authorisation block:
// receiver and authorisation state encodings, counter widths, command bytes.
package cmd_auth_pkg;

    typedef enum logic [1:0] {
        RX_ARM  = 2'd0,
        RX_IDLE = 2'd1,
        RX_RECV = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        AUTH_OFF  = 2'd0,
        AUTH_PWR1 = 2'd1,
        AUTH_PWR2 = 2'd2
    } auth_state_t;

    localparam int BAUD_CNT_W = 13;
    localparam int BIT_CNT_W  = 4;

    localparam logic [7:0] DEF_CMD_GO   = 8'h47;
    localparam logic [7:0] DEF_CMD_STOP = 8'h53;

endpackage

// File: rtl/cmd_auth_uart_rx.sv
// 8N1 UART receiver with input synchronizer; re-arms after reset or a framing
// error only once the line has been idle for a full bit time.
module uart_rx
    import cmd_auth_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rdy,
    output logic [7:0] data,
    output logic       frm_err,
    output rx_state_t  state
);

    localparam logic [BAUD_CNT_W-1:0] LAST_CNT = BAUD_CNT_W'(BAUD_DIV - 1);
    localparam logic [BAUD_CNT_W-1:0] HALF_CNT = BAUD_CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [BIT_CNT_W-1:0]  STOP_BIT = BIT_CNT_W'(9);

    logic                  rx_meta;
    logic                  rx_sync;
    logic                  rx_prev;
    rx_state_t             state_next;
    logic [BAUD_CNT_W-1:0] baud_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [7:0]            shift;
    logic                  sample;
    logic [BAUD_CNT_W-1:0] target;

    // Flops load 1 so a reset never manufactures a falling edge on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        target     = (bit_cnt == '0) ? HALF_CNT : LAST_CNT;
        case (state)
            RX_ARM: begin
                if (rx_sync && baud_cnt == LAST_CNT) state_next = RX_IDLE;
            end
            RX_IDLE: begin
                if (rx_prev && !rx_sync) state_next = RX_RECV;
            end
            RX_RECV: begin
                if (baud_cnt == target) begin
                    sample = 1'b1;
                    if (bit_cnt == '0 && rx_sync) begin
                        state_next = RX_IDLE;
                    end else if (bit_cnt == STOP_BIT) begin
                        state_next = rx_sync ? RX_IDLE : RX_ARM;
                    end
                end
            end
            default: state_next = RX_ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RX_ARM;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            data     <= '0;
            rdy      <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            state   <= state_next;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            if (state_next != state) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state == RX_ARM) begin
                baud_cnt <= rx_sync ? baud_cnt + BAUD_CNT_W'(1) : '0;
            end else if (state == RX_RECV) begin
                if (sample) begin
                    baud_cnt <= '0;
                    bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                end else begin
                    baud_cnt <= baud_cnt + BAUD_CNT_W'(1);
                end
            end else begin
                baud_cnt <= '0;
            end
            // LSB arrives first, so shift right and fill from the top.
            if (state == RX_RECV && sample && bit_cnt != '0 && bit_cnt != STOP_BIT) begin
                shift <= {rx_sync, shift[7:1]};
            end
            if (state == RX_RECV && sample && bit_cnt == STOP_BIT) begin
                if (rx_sync) begin
                    data <= shift;
                    rdy  <= 1'b1;
                end else begin
                    frm_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cmd_auth.sv
// Segway power authorisation: a BLE UART command stream plus the rider sensor
// decide whether the platform may balance and drive its motors.
module cmd_auth
    import cmd_auth_pkg::*;
#(
    parameter int         BAUD_DIV = 2604,
    parameter logic [7:0] CMD_GO   = DEF_CMD_GO,
    parameter logic [7:0] CMD_STOP = DEF_CMD_STOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic        rider_off,
    output logic        pwr_up,
    output logic        rx_rdy,
    output logic [7:0]  rx_data,
    output logic        frm_err,
    output rx_state_t   rx_state,
    output auth_state_t auth_state
);

    auth_state_t auth_next;

    // rx_rdy is a valid-only strobe with no ready/backpressure: rx_data is
    // guaranteed valid in the rx_rdy cycle and held until the next byte.
    uart_rx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart_rx (
        .clk    (clk),
        .rst    (rst),
        .rx     (RX),
        .rdy    (rx_rdy),
        .data   (rx_data),
        .frm_err(frm_err),
        .state  (rx_state)
    );

    always_comb begin
        auth_next = auth_state;
        case (auth_state)
            AUTH_OFF: begin
                if (rx_rdy && rx_data == CMD_GO) auth_next = AUTH_PWR1;
            end
            AUTH_PWR1: begin
                if (rx_rdy && rx_data == CMD_STOP) begin
                    auth_next = rider_off ? AUTH_OFF : AUTH_PWR2;
                end
            end
            AUTH_PWR2: begin
                // A fresh GO re-authorises even if the rider steps off that cycle.
                if (rx_rdy && rx_data == CMD_GO) auth_next = AUTH_PWR1;
                else if (rider_off)              auth_next = AUTH_OFF;
            end
            default: auth_next = AUTH_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            auth_state <= AUTH_OFF;
            pwr_up     <= 1'b0;
        end else begin
            auth_state <= auth_next;
            pwr_up     <= (auth_next != AUTH_OFF);
        end
    end

endmodule
